// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared 8-bit internal data bus (16 requesters).
// Each tenure runs grant -> hold -> release -> one turnaround cycle; all outputs are registered.
module bus_arbiter_rr #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant_onehot,
  output logic        timeout
);

  localparam int unsigned N_REQ  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit          HAS_TO = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [N_REQ-1:0]   grant_onehot_q, grant_onehot_d;
  logic               timeout_q, timeout_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               rel_vol;
  logic               rel_to;
  logic               release_c;

  // First requester after last_idx, wrapping mod 16; last_idx itself is checked last.
  function automatic logic [IDX_W:0] pick_next(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {win_found, win_idx} = pick_next(req, last_idx_q);
  end

  // Voluntary release (done or withdrawal) takes precedence over the hold-limit release.
  assign rel_vol   = done | ~req[grant_idx_q];
  assign rel_to    = HAS_TO && (cnt_q == CNT_W'(MAX_HOLD));
  assign release_c = rel_vol | rel_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = win_found ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_d = release_c ? ST_GAP : ST_BUSY;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_valid_d  = 1'b0;
    grant_idx_d    = '0;
    grant_onehot_d = '0;
    timeout_d      = 1'b0;
    cnt_d          = cnt_q;
    last_idx_d     = last_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_valid_d  = 1'b1;
          grant_idx_d    = win_idx;
          grant_onehot_d = N_REQ'(1) << win_idx;
          cnt_d          = CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (release_c) begin
          last_idx_d = grant_idx_q;
          timeout_d  = rel_to & ~rel_vol;
          cnt_d      = '0;
        end else begin
          grant_valid_d  = 1'b1;
          grant_idx_d    = grant_idx_q;
          grant_onehot_d = grant_onehot_q;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      last_idx_q     <= IDX_W'(15);
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      last_idx_q     <= last_idx_d;
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      timeout_q      <= timeout_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a tenure-level reference model predicts each cycle's
// outputs into a queue, and a negedge monitor compares them against the DUT.
module tb_bus_arbiter_rr;

  localparam int unsigned MAX_HOLD = 4;

  typedef struct packed {
    logic        v;
    logic [3:0]  idx;
    logic [15:0] oh;
    logic        to;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic        timeout;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_to     = 0;

  // Model state: who owns the bus, how long they have held it, turnaround pending, last winner.
  int   m_owner = -1;
  int   m_held  = 0;
  bit   m_gap   = 1'b0;
  int   m_last  = 15;

  bus_arbiter_rr #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
  endtask

  // Reference model: predicts the outputs that follow each rising edge.
  always @(posedge clk) begin
    exp_t e;
    bit   vol;
    bit   forced;
    bit   to_now;
    to_now = 1'b0;
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_gap   = 1'b0;
      m_last  = 15;
    end else if (m_owner >= 0) begin
      vol    = done || !req[m_owner];
      forced = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (vol || forced) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1'b1;
        to_now  = forced && !vol;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int k = 1; k <= 16; k++) begin
        int c;
        c = (m_last + k) % 16;
        if (req[c]) begin
          m_owner = c;
          m_held  = 1;
          break;
        end
      end
    end
    e.v   = (m_owner >= 0);
    e.idx = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
    e.oh  = (m_owner >= 0) ? (16'd1 << m_owner) : 16'h0000;
    e.to  = to_now;
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs once per cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.to && timeout) n_to++;
      check("cycle_out", {grant_valid, grant_idx, grant_onehot, timeout}, e);
    end
  end

  task automatic drive(input logic [15:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1 check("async_rst", {grant_valid, grant_idx, grant_onehot, timeout}, 22'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] r;
    bit          got_grant;
    rst_n = 1'b0;
    req   = 16'hFFFF;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {grant_valid, grant_idx, grant_onehot, timeout}, 22'h0);
    rst_n = 1'b1;

    // All requesting after reset: idx 0 first, then hold-limit releases rotate.
    repeat (14) drive(16'hFFFF, 1'b0);
    repeat (3)  drive(16'h0000, 1'b0);

    // Lone requester 5 with a single done pulse, then re-granted.
    repeat (3) drive(16'h0020, 1'b0);
    drive(16'h0020, 1'b1);
    repeat (6) drive(16'h0020, 1'b0);
    repeat (3) drive(16'h0000, 1'b0);

    // Round robin among 3, 7, 12.
    repeat (16) drive(16'h1088, 1'b1);
    repeat (3)  drive(16'h0000, 1'b0);

    // Hold limit on requester 8, then 8 and 9 both asking.
    repeat (8)  drive(16'h0100, 1'b0);
    repeat (12) drive(16'h0300, 1'b0);
    repeat (3)  drive(16'h0000, 1'b0);

    // done arriving at various points including the hold-limit cycle.
    for (int d = 0; d < 7; d++) begin
      repeat (3) drive(16'h0000, 1'b0);
      repeat (d) drive(16'h0010, 1'b0);
      repeat (3) drive(16'h0010, 1'b1);
    end

    // Requester withdraws mid-tenure.
    repeat (3) drive(16'h0040, 1'b0);
    repeat (3) drive(16'h0000, 1'b0);

    // Async reset while requester 12 owns the bus.
    got_grant = 1'b0;
    for (int i = 0; i < 10 && !got_grant; i++) begin
      drive(16'h1000, 1'b0);
      got_grant = grant_valid;
    end
    check("wait_grant12", 22'(got_grant), 22'd1);
    drive(16'h1000, 1'b0);
    apply_reset();
    repeat (6) drive(16'hFFFF, 1'b1);

    // Randomized traffic with occasional resets.
    r = 16'h0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       r = 16'h0000;
          1:       r = 16'd1 << $urandom_range(0, 15);
          2:       r = 16'($urandom & $urandom);
          default: r = 16'($urandom);
        endcase
      end
      drive(r, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 199) == 0) apply_reset();
    end

    repeat (4) drive(16'h0000, 1'b0);
    check("timeout_seen", 22'(n_to > 0), 22'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
